// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// seven_seg_scanner : multiplexed common-anode 7-segment driver with a
//                     double-buffered image and an inter-digit guard interval
// Revision 1.0
// ============================================================================
module seven_seg_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    SCAN_TICK,
  input  logic                    WR_EN,
  input  logic [4*NUM_DIGITS-1:0] WR_DATA,
  input  logic [NUM_DIGITS-1:0]   WR_DP,
  input  logic [NUM_DIGITS-1:0]   WR_BLANK,
  output logic                    WR_READY,
  output logic [6:0]              SEG_OUT,
  output logic                    DP_OUT,
  output logic [NUM_DIGITS-1:0]   AN_OUT,
  output logic                    FRAME_DONE
);

  localparam int                     IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0]       LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [3:0]             GUARD_LOAD = 4'(GUARD_CYCLES);
  localparam logic [NUM_DIGITS-1:0]  ALL_OFF    = '1;
  localparam logic [0:0]             ST_SHOW    = 1'b0;
  localparam logic [0:0]             ST_GUARD   = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [3:0]              gcnt_q, gcnt_d;
  logic                    full_q, full_d;
  logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
  logic [4*NUM_DIGITS-1:0] act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    frame_done_q, frame_done_d;
  logic                    wrap;
  logic                    accept;
  logic [3:0]              nibble;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    case (n)
      4'h0: hex_to_seg = 7'h40;
      4'h1: hex_to_seg = 7'h79;
      4'h2: hex_to_seg = 7'h24;
      4'h3: hex_to_seg = 7'h30;
      4'h4: hex_to_seg = 7'h19;
      4'h5: hex_to_seg = 7'h12;
      4'h6: hex_to_seg = 7'h02;
      4'h7: hex_to_seg = 7'h78;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h10;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h03;
      4'hC: hex_to_seg = 7'h46;
      4'hD: hex_to_seg = 7'h21;
      4'hE: hex_to_seg = 7'h06;
      default: hex_to_seg = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_SHOW;
      idx_q        <= '0;
      gcnt_q       <= '0;
      full_q       <= 1'b0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '1;
      an_q         <= '1;
      seg_q        <= '1;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      gcnt_q       <= gcnt_d;
      full_q       <= full_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      act_data_q   <= act_data_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    gcnt_d       = gcnt_q;
    full_d       = full_q;
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    act_data_d   = act_data_q;
    act_dp_d     = act_dp_q;
    act_blank_d  = act_blank_q;
    wrap         = SCAN_TICK && (idx_q == LAST_IDX);
    accept       = WR_EN && !full_q;

    if (SCAN_TICK) begin
      idx_d  = wrap ? '0 : idx_q + IDX_W'(1);
      gcnt_d = GUARD_LOAD;
      state_d = (GUARD_CYCLES > 0) ? ST_GUARD : ST_SHOW;
    end else if (state_q == ST_GUARD) begin
      if (gcnt_q <= 4'd1) begin
        state_d = ST_SHOW;
      end else begin
        gcnt_d = gcnt_q - 4'd1;
      end
    end

    // Swap requires full and acceptance requires empty, so the two never coincide.
    if (wrap && full_q) begin
      act_data_d  = pend_data_q;
      act_dp_d    = pend_dp_q;
      act_blank_d = pend_blank_q;
      full_d      = 1'b0;
    end
    if (accept) begin
      pend_data_d  = WR_DATA;
      pend_dp_d    = WR_DP;
      pend_blank_d = WR_BLANK;
      full_d       = 1'b1;
    end
  end

  // Outputs are derived from next-state values so they settle with the state.
  always_comb begin
    nibble       = act_data_d[{idx_d, 2'b00} +: 4];
    frame_done_d = wrap;
    an_d         = ALL_OFF;
    seg_d        = 7'h7F;
    dp_d         = 1'b1;
    if ((state_d == ST_SHOW) && !act_blank_d[idx_d]) begin
      an_d  = ~(NUM_DIGITS'(1) << idx_d);
      seg_d = hex_to_seg(nibble);
      dp_d  = !act_dp_d[idx_d];
    end
  end

  assign WR_READY   = !full_q;
  assign SEG_OUT    = seg_q;
  assign DP_OUT     = dp_q;
  assign AN_OUT     = an_q;
  assign FRAME_DONE = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
`default_nettype none
// tb_seven_seg_scanner : directed stimulus with a time-since-tick display model
// checked every cycle, plus literal expectations taken from worked examples.
module tb_seven_seg_scanner;

  localparam int N = 4;
  localparam int G = 2;
  localparam logic [6:0] SEG_TBL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         SCAN_TICK = 1'b0;
  logic         WR_EN = 1'b0;
  logic [15:0]  WR_DATA = '0;
  logic [3:0]   WR_DP = '0;
  logic [3:0]   WR_BLANK = '0;
  logic         WR_READY;
  logic [6:0]   SEG_OUT;
  logic         DP_OUT;
  logic [3:0]   AN_OUT;
  logic         FRAME_DONE;

  seven_seg_scanner #(.NUM_DIGITS(N), .GUARD_CYCLES(G)) dut (
    .CLK(CLK), .RESET(RESET), .SCAN_TICK(SCAN_TICK), .WR_EN(WR_EN),
    .WR_DATA(WR_DATA), .WR_DP(WR_DP), .WR_BLANK(WR_BLANK), .WR_READY(WR_READY),
    .SEG_OUT(SEG_OUT), .DP_OUT(DP_OUT), .AN_OUT(AN_OUT), .FRAME_DONE(FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  // Model: displayed digit, cycles elapsed since the last tick, two image buffers.
  int       m_idx = 0;
  int       m_since = 1000;
  logic [3:0] m_act [N];
  logic [3:0] m_pend [N];
  bit       m_adp [N];
  bit       m_ablank [N];
  bit       m_pdp [N];
  bit       m_pblank [N];
  bit       m_full = 0;
  bit       m_frame = 0;
  bit       m_ok = 0;

  always @(posedge CLK) begin : model
    bit acc;
    acc = WR_EN && !m_full;
    if (RESET) begin
      m_idx = 0; m_since = 1000; m_full = 0; m_frame = 0;
      for (int k = 0; k < N; k++) begin
        m_act[k] = 4'h0; m_adp[k] = 0; m_ablank[k] = 1;
      end
    end else begin
      m_frame = 0;
      if (SCAN_TICK) begin
        m_since = 0;
        if (m_idx == N - 1) begin
          m_idx = 0;
          m_frame = 1;
          if (m_full) begin
            for (int k = 0; k < N; k++) begin
              m_act[k] = m_pend[k]; m_adp[k] = m_pdp[k]; m_ablank[k] = m_pblank[k];
            end
            m_full = 0;
          end
        end else begin
          m_idx = m_idx + 1;
        end
      end else if (m_since < 1000) begin
        m_since = m_since + 1;
      end
      if (acc) begin
        for (int k = 0; k < N; k++) begin
          m_pend[k] = WR_DATA[4*k +: 4]; m_pdp[k] = WR_DP[k]; m_pblank[k] = WR_BLANK[k];
        end
        m_full = 1;
      end
    end
    m_ok = 1;
  end

  int n_assert = 0;
  int n_fail = 0;
  int fd_count = 0;
  int lit_count = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance one clock and compare every output against the model.
  task automatic cyc();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    @(negedge CLK);
    if (!m_ok) return;
    if (m_since < G || m_ablank[m_idx]) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      e_an  = ~(4'b0001 << m_idx);
      e_seg = SEG_TBL[m_act[m_idx]];
      e_dp  = !m_adp[m_idx];
    end
    check("AN_OUT", {28'd0, AN_OUT}, {28'd0, e_an});
    check("SEG_OUT", {25'd0, SEG_OUT}, {25'd0, e_seg});
    check("DP_OUT", {31'd0, DP_OUT}, {31'd0, e_dp});
    check("FRAME_DONE", {31'd0, FRAME_DONE}, {31'd0, m_frame});
    check("WR_READY", {31'd0, WR_READY}, {31'd0, !m_full});
    if (FRAME_DONE) fd_count++;
    if (AN_OUT != 4'hF) lit_count++;
  endtask

  task automatic wr(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    WR_EN = 1'b1; WR_DATA = d; WR_DP = dp; WR_BLANK = bl;
    cyc();
    WR_EN = 1'b0;
  endtask

  task automatic tick();
    SCAN_TICK = 1'b1; cyc(); SCAN_TICK = 1'b0;
  endtask

  // Count dark cycles from the current observation until a digit lights.
  task automatic settle(input int e_ones, input logic [3:0] e_an, input logic [6:0] e_seg, input logic e_dp);
    int ones = 0;
    while (AN_OUT == 4'hF && ones < 16) begin
      ones++;
      cyc();
    end
    if (ones >= 16) begin
      check("digit_timeout", 32'd1, 32'd0);
    end else begin
      check("guard_len", ones, e_ones);
      check("lit_an", {28'd0, AN_OUT}, {28'd0, e_an});
      check("lit_seg", {25'd0, SEG_OUT}, {25'd0, e_seg});
      check("lit_dp", {31'd0, DP_OUT}, {31'd0, e_dp});
    end
  endtask

  task automatic tick_show(input logic [3:0] e_an, input logic [6:0] e_seg, input logic e_dp);
    tick();
    settle(G, e_an, e_seg, e_dp);
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      m_act[k] = 0; m_pend[k] = 0; m_adp[k] = 0; m_ablank[k] = 1; m_pdp[k] = 0; m_pblank[k] = 0;
    end
    cyc(); cyc(); cyc();
    RESET = 1'b0;
    cyc();
    check("rst_an", {28'd0, AN_OUT}, 32'hF);
    check("rst_seg", {25'd0, SEG_OUT}, 32'h7F);
    check("rst_ready", {31'd0, WR_READY}, 32'd1);
    check("rst_fd", {31'd0, FRAME_DONE}, 32'd0);

    // Dark display, 8 ticks: wraps after the 4th and 8th
    fd_count = 0; lit_count = 0;
    for (int t = 0; t < 8; t++) begin
      tick(); cyc(); cyc(); cyc();
      if (t == 3) check("fd_after_4", fd_count, 32'd1);
    end
    check("fd_after_8", fd_count, 32'd2);
    check("dark_lit", lit_count, 32'd0);

    // F8A1 image, shown from the frame after the next wrap
    wr(16'hF8A1, 4'b0000, 4'b0000);
    tick(); cyc(); tick(); cyc(); tick(); cyc();
    tick_show(4'b1110, 7'h79, 1'b1);
    tick_show(4'b1101, 7'h08, 1'b1);
    tick_show(4'b1011, 7'h00, 1'b1);
    tick_show(4'b0111, 7'h0E, 1'b1);

    // Back-to-back writes: second one ignored
    WR_EN = 1'b1; WR_DATA = 16'h1234; WR_DP = '0; WR_BLANK = '0;
    cyc();
    WR_DATA = 16'h5678;
    cyc();
    WR_EN = 1'b0;
    check("ready_low", {31'd0, WR_READY}, 32'd0);
    tick_show(4'b1110, 7'h19, 1'b1);
    check("ready_back", {31'd0, WR_READY}, 32'd1);
    tick_show(4'b1101, 7'h30, 1'b1);

    // Blank digit 2, decimal point on digit 0
    wr(16'h9876, 4'b0001, 4'b0100);
    tick_show(4'b1011, 7'h24, 1'b1);
    tick_show(4'b0111, 7'h79, 1'b1);
    tick_show(4'b1110, 7'h02, 1'b0);
    tick_show(4'b1101, 7'h78, 1'b1);
    tick();
    for (int c = 0; c < 4; c++) begin
      cyc();
      check("blank_an", {28'd0, AN_OUT}, 32'hF);
      check("blank_seg", {25'd0, SEG_OUT}, 32'h7F);
    end
    tick_show(4'b0111, 7'h10, 1'b1);

    // Tick re-asserted in the second guard cycle restarts the guard
    wr(16'h4321, 4'b0000, 4'b0000);
    tick_show(4'b1110, 7'h79, 1'b1);
    SCAN_TICK = 1'b1; cyc();
    SCAN_TICK = 1'b0; cyc();
    SCAN_TICK = 1'b1; cyc();
    SCAN_TICK = 1'b0;
    settle(2, 4'b1011, 7'h30, 1'b1);

    // Tick held two cycles advances twice (through the wrap)
    fd_count = 0;
    SCAN_TICK = 1'b1; cyc(); cyc();
    SCAN_TICK = 1'b0;
    settle(2, 4'b1110, 7'h79, 1'b1);
    check("held_fd", fd_count, 32'd1);
    tick_show(4'b1101, 7'h24, 1'b1);
    tick_show(4'b1011, 7'h30, 1'b1);

    // Reset at idx 2 with pending full discards everything
    wr(16'hABCD, 4'b0000, 4'b0000);
    check("pend_full", {31'd0, WR_READY}, 32'd0);
    RESET = 1'b1; cyc(); RESET = 1'b0;
    check("rst2_an", {28'd0, AN_OUT}, 32'hF);
    check("rst2_ready", {31'd0, WR_READY}, 32'd1);
    fd_count = 0; lit_count = 0;
    for (int t = 0; t < 4; t++) begin
      tick(); cyc(); cyc(); cyc();
    end
    cyc(); cyc(); cyc(); cyc();
    check("rst2_fd", fd_count, 32'd1);
    check("rst2_dark", lit_count, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed driver for a common-anode multi-digit seven-segment display. It sits directly downstream of the generic prescaler counter and consumes that counter's one-cycle terminal-count strobe as its digit-advance tick. It holds a double-buffered display image written by the bus-side peripheral logic and swaps buffers only at frame boundaries, so a digit never tears mid-frame. Between digits it inserts a short all-anodes-off guard interval to suppress ghosting.

## Interface
- NUM_DIGITS, 4: number of multiplexed digits, 2..8.
- GUARD_CYCLES, 2: CLK cycles with all anodes off after each digit advance, 0..15.
- CLK  in  1  clock.
- RESET  in  1  reset; RESET, synchronous, active-high; clock CLK.
- SCAN_TICK  in  1  one-cycle strobe from the upstream prescaler; advances to the next digit.
- WR_EN  in  1  write request for a new display image.
- WR_DATA  in  4*NUM_DIGITS  hex nibbles; digit k = WR_DATA[4k+3:4k].
- WR_DP  in  NUM_DIGITS  decimal-point enables, 1 = lit.
- WR_BLANK  in  NUM_DIGITS  per-digit blank mask, 1 = digit dark.
- WR_READY  out  1  pending buffer empty; a write is accepted when WR_EN && WR_READY.
- SEG_OUT  out  7  segments {g,f,e,d,c,b,a}, active-low.
- DP_OUT  out  1  decimal point, active-low.
- AN_OUT  out  NUM_DIGITS  digit anodes, active-low; bit k drives digit k.
- FRAME_DONE  out  1  one-cycle pulse when the scan wraps from the last digit to digit 0.

## Operation
- Storage: the pending buffer (data, dp, blank, full flag) and the active buffer (data, dp, blank).
  - An accepted write loads the pending buffer and sets full; WR_READY = !full.
- Digit index idx runs 0..NUM_DIGITS-1.
  - On SCAN_TICK, idx increments, wrapping from NUM_DIGITS-1 to 0.
  - A wrap is a frame boundary: FRAME_DONE pulses, and if pending is full, pending is copied to active and full clears.
- The FSM has two states, SHOW and GUARD.
  - SHOW: AN_OUT has only bit idx low, unless the active blank[idx] is set, in which case AN_OUT is all ones.
  - SCAN_TICK with GUARD_CYCLES > 0 moves to GUARD and loads gcnt = GUARD_CYCLES. With GUARD_CYCLES = 0 the FSM stays in SHOW.
  - GUARD: AN_OUT is all ones and gcnt decrements each cycle. When gcnt reaches 1, the FSM returns to SHOW.
  - SCAN_TICK during GUARD advances idx again and reloads gcnt.
- Hex decode of active nibble idx, active-low {g..a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78.
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- DP_OUT = !active_dp[idx].
- SEG_OUT and DP_OUT are forced to all ones whenever AN_OUT is all ones.
- All outputs are registered.

## Timing
- Reset values:
  - idx = 0, state = SHOW.
  - Active data = 0, active dp = 0, active blank = all ones (display dark).
  - Pending buffer empty.
  - AN_OUT, SEG_OUT, DP_OUT all ones; WR_READY = 1; FRAME_DONE = 0.
- SCAN_TICK sampled at edge t: AN_OUT is all ones from t+1 through t+GUARD_CYCLES. The new digit appears at t+GUARD_CYCLES+1.
- With GUARD_CYCLES = 0 the new digit appears at t+1.
- Frame boundary at edge t:
  - FRAME_DONE is high for cycle t+1 only.
  - The new active image drives the digit-0 output at the same latency as any other digit.
  - WR_READY rises at t+1.
- Write accepted at edge t: WR_READY is low from t+1.
- WR_EN while WR_READY = 0 is ignored; the pending contents are unchanged.
- A write and a frame-boundary swap in the same cycle cannot collide: a swap needs full = 1, and acceptance needs full = 0.
- A write accepted at the wrap edge with pending empty stays pending until the next wrap.
- WR_EN in consecutive cycles: only the first is accepted.
- RESET mid-frame or mid-guard: all state returns to reset values on the next edge, and pending contents are discarded.
- SCAN_TICK asserted for multiple consecutive cycles counts as one advance per cycle.

## Test plan
- Reset, no writes, 8 ticks -> AN_OUT stays 1111 throughout, FRAME_DONE pulses after ticks 4 and 8, WR_READY = 1.
- Write WR_DATA=16'hF8A1, WR_DP=0000, WR_BLANK=0000, GUARD_CYCLES=2, then tick until the wrap -> following frame shows:
  - AN 1110 with SEG 79.
  - AN 1101 with SEG 08.
  - AN 1011 with SEG 00.
  - AN 0111 with SEG 0E.
  - Each digit is preceded by exactly 2 cycles of AN 1111.
- Write 16'h1234, then a second write of 16'h5678 while WR_READY=0 -> second write ignored; after the wrap, digit 0 shows SEG 19 (nibble 4).
- WR_BLANK=0100, WR_DP=0001 -> digit 2 slot has AN 1111 and SEG 7F; digit 0 has DP_OUT=0, all others DP_OUT=1.
- SCAN_TICK re-asserted at the second GUARD cycle -> idx advances twice, guard restarts with 2 full cycles, and no anode is enabled in between.
- RESET asserted while idx=2 with pending full -> next cycle AN_OUT=1111, WR_READY=1, idx=0; the subsequent wrap shows a dark display.
